// File: rtl/stdp_pkg.sv
// Shared defaults and types for the STDP event scheduler.
package stdp_pkg;
  localparam int N_PRE_DEF  = 5;
  localparam int AGE_W_DEF  = 8;
  localparam int WINDOW_DEF = 64;
  localparam int IDX_W      = $clog2(N_PRE_DEF);

  typedef struct packed {
    logic                 ltp;
    logic [AGE_W_DEF-1:0] dt;
  } stdp_evt_t;
endpackage

// File: rtl/stdp_rr_pick.sv
// Combinational round-robin picker: first set bit of pend at or after rr_ptr.
module stdp_rr_pick
  import stdp_pkg::*;
#(
  parameter int N = N_PRE_DEF
) (
  input  logic [N-1:0]     pend,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && pend[(int'(rr_ptr) + k) % N]) begin
        found = 1'b1;
        idx   = IDX_W'((int'(rr_ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/stdp_event_sched.sv
// STDP event scheduler: spike ages, pairing detection, per-synapse slots and a
// round-robin valid/ready output feeding one shared weight-update engine.
module stdp_event_sched
  import stdp_pkg::*;
#(
  parameter int N_PRE  = N_PRE_DEF,
  parameter int AGE_W  = AGE_W_DEF,
  parameter int WINDOW = WINDOW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_PRE-1:0] pre_spike,
  input  logic             post_spike,
  input  logic             upd_ready,
  output logic             upd_valid,
  output logic [IDX_W-1:0] upd_idx,
  output logic             upd_ltp,
  output logic [AGE_W-1:0] upd_dt,
  output logic [N_PRE-1:0] pend,
  output logic             overrun
);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [AGE_W:0]   WIN_L   = (AGE_W+1)'(WINDOW);

  logic [N_PRE-1:0][AGE_W-1:0] age_pre_q, age_pre_d;
  logic [AGE_W-1:0]            age_post_q, age_post_d;
  stdp_evt_t [N_PRE-1:0]       slot_q, slot_d, ev;
  logic [N_PRE-1:0]            ev_vld, pend_q, pend_d;
  stdp_evt_t                   out_q, out_d;
  logic [IDX_W-1:0]            idx_q, idx_d, rr_q, rr_d, pick_idx;
  logic                        vld_q, vld_d, ovr_q, ovr_d, pick_found, load, ld;

  always_comb begin
    age_post_d = post_spike ? '0 : ((age_post_q == AGE_MAX) ? age_post_q : age_post_q + 1'b1);
    for (int i = 0; i < N_PRE; i++)
      age_pre_d[i] = pre_spike[i] ? '0 :
                     ((age_pre_q[i] == AGE_MAX) ? age_pre_q[i] : age_pre_q[i] + 1'b1);
  end

  // Pairing uses pre-update ages; a coincident pre/post is LTP dt=0 only.
  always_comb begin
    for (int i = 0; i < N_PRE; i++) begin
      ev_vld[i] = 1'b0;
      ev[i]     = '0;
      if (post_spike) begin
        if (pre_spike[i]) begin
          ev_vld[i] = 1'b1;
          ev[i].ltp = 1'b1;
        end else if ({1'b0, age_pre_q[i]} < WIN_L) begin
          ev_vld[i] = 1'b1;
          ev[i].ltp = 1'b1;
          ev[i].dt  = age_pre_q[i];
        end
      end else if (pre_spike[i] && ({1'b0, age_post_q} < WIN_L)) begin
        ev_vld[i] = 1'b1;
        ev[i].dt  = age_post_q;
      end
    end
  end

  stdp_rr_pick #(.N(N_PRE)) u_pick (
    .pend   (pend_q),
    .rr_ptr (rr_q),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  assign load = !vld_q || upd_ready;
  assign ld   = load && pick_found;

  always_comb begin
    vld_d  = vld_q;
    out_d  = out_q;
    idx_d  = idx_q;
    rr_d   = rr_q;
    pend_d = pend_q;
    slot_d = slot_q;
    ovr_d  = ovr_q;
    if (load) vld_d = pick_found;
    if (ld) begin
      out_d            = slot_q[pick_idx];
      idx_d            = pick_idx;
      rr_d             = (pick_idx == IDX_W'(N_PRE-1)) ? '0 : pick_idx + 1'b1;
      pend_d[pick_idx] = 1'b0;
    end
    // A slot being drained this edge hands its old event to the output, so
    // only a hit on an undrained pending slot loses data.
    for (int i = 0; i < N_PRE; i++) begin
      if (ev_vld[i]) begin
        if (pend_q[i] && !(ld && pick_idx == IDX_W'(i))) ovr_d = 1'b1;
        slot_d[i] = ev[i];
        pend_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_pre_q  <= '1;
      age_post_q <= '1;
      slot_q     <= '0;
      pend_q     <= '0;
      out_q      <= '0;
      idx_q      <= '0;
      rr_q       <= '0;
      vld_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      age_pre_q  <= age_pre_d;
      age_post_q <= age_post_d;
      slot_q     <= slot_d;
      pend_q     <= pend_d;
      out_q      <= out_d;
      idx_q      <= idx_d;
      rr_q       <= rr_d;
      vld_q      <= vld_d;
      ovr_q      <= ovr_d;
    end
  end

  assign upd_valid = vld_q;
  assign upd_idx   = idx_q;
  assign upd_ltp   = out_q.ltp;
  assign upd_dt    = out_q.dt;
  assign pend      = pend_q;
  assign overrun   = ovr_q;
endmodule
